evt_neuron_seq: RTL and testbench

- Sequencer that time-multiplexes one neuron datapath (ALIF update unit) across a bank of neuron states held in single-port SRAM.
- For each accepted input event, it sweeps neurons 0..n-1: read state, drive datapath, write back the updated state, emit a spike event with the neuron index when the datapath fires.
- Sits between the event-stream filter (upstream) and the state memory plus the spike output stream (downstream).

---
 rtl/evt_neuron_seq.sv | 137 +++++++++++++
 tb/tb_evt_neuron_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_neuron_seq.sv
// Event-driven neuron sequencer: for each accepted event, sweeps neuron states
// through one shared ALIF datapath (read, execute, write back, optional spike).
module evt_neuron_seq #(
  parameter int N_NEURONS = 64,
  parameter int STATE_W   = 32,
  parameter int WEIGHT_W  = 4,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                evt_valid_i,
  output logic                evt_ready_o,
  input  logic [WEIGHT_W-1:0] evt_weight_i,
  input  logic [7:0]          evt_time_i,
  input  logic                evt_force_i,
  input  logic [IDX_W:0]      cfg_n_active_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [IDX_W-1:0]    mem_addr_o,
  output logic [STATE_W-1:0]  mem_wdata_o,
  input  logic [STATE_W-1:0]  mem_rdata_i,
  output logic                dp_enable_o,
  output logic [WEIGHT_W-1:0] dp_weight_o,
  output logic [7:0]          dp_time_o,
  output logic                dp_force_o,
  output logic [STATE_W-1:0]  dp_state_o,
  input  logic [STATE_W-1:0]  dp_state_i,
  input  logic                dp_spike_i,
  output logic                spk_valid_o,
  input  logic                spk_ready_i,
  output logic [IDX_W-1:0]    spk_id_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_SPIKE} state_t;

  localparam logic [IDX_W:0] LP_N_MAX = (IDX_W+1)'(N_NEURONS);

  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_last;
  logic [WEIGHT_W-1:0] r_weight;
  logic [7:0]          r_time;
  logic                r_force;
  logic [STATE_W-1:0]  r_wbuf;
  logic                r_spk_flag;

  logic                w_accept;
  logic                w_advance;
  logic                w_last;
  logic [IDX_W:0]      w_n_sat;
  logic [IDX_W:0]      w_n_minus1;

  assign w_n_sat    = (cfg_n_active_i > LP_N_MAX) ? LP_N_MAX : cfg_n_active_i;
  assign w_n_minus1 = w_n_sat - 1'b1;
  assign w_accept   = evt_valid_i && (r_state == S_IDLE);
  assign w_last     = (r_idx == r_last);
  // Advance leaves a neuron either straight from WRITE or after the spike handshake.
  assign w_advance  = ((r_state == S_WRITE) && !r_spk_flag) ||
                      ((r_state == S_SPIKE) && spk_ready_i);

  assign mem_addr_o  = r_idx;
  assign mem_wdata_o = r_wbuf;
  assign spk_id_o    = r_idx;
  assign dp_weight_o = r_weight;
  assign dp_time_o   = r_time;
  assign dp_force_o  = r_force;
  assign dp_state_o  = mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    evt_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    dp_enable_o = 1'b0;
    spk_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        evt_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (w_accept && (w_n_sat != '0)) w_next = S_READ;
      end
      S_READ: begin
        mem_req_o = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        dp_enable_o = 1'b1;
        w_next      = S_WRITE;
      end
      S_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (r_spk_flag)  w_next = S_SPIKE;
        else if (w_last) w_next = S_IDLE;
        else             w_next = S_READ;
      end
      S_SPIKE: begin
        spk_valid_o = 1'b1;
        if (spk_ready_i) w_next = w_last ? S_IDLE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx      <= '0;
      r_last     <= '0;
      r_weight   <= '0;
      r_time     <= '0;
      r_force    <= 1'b0;
      r_wbuf     <= '0;
      r_spk_flag <= 1'b0;
    end else begin
      if (w_accept) begin
        r_weight <= evt_weight_i;
        r_time   <= evt_time_i;
        r_force  <= evt_force_i;
        r_last   <= w_n_minus1[IDX_W-1:0];
        r_idx    <= '0;
      end
      if (r_state == S_EXEC) begin
        r_wbuf     <= dp_state_i;
        r_spk_flag <= dp_spike_i;
      end
      if (w_advance && !w_last) r_idx <= r_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_evt_neuron_seq.sv
// Randomized bench for evt_neuron_seq: memory and datapath emulation plus an
// event-level reference model of the expected memory/spike traffic and timing.
module tb_evt_neuron_seq;
  localparam int N  = 64;
  localparam int SW = 32;
  localparam int WW = 4;
  localparam int IW = 6;

  logic          clk_i, rst_ni;
  logic          evt_valid_i, evt_ready_o, evt_force_i;
  logic [WW-1:0] evt_weight_i;
  logic [7:0]    evt_time_i;
  logic [IW:0]   cfg_n_active_i;
  logic          mem_req_o, mem_we_o;
  logic [IW-1:0] mem_addr_o;
  logic [SW-1:0] mem_wdata_o, mem_rdata_i;
  logic          dp_enable_o, dp_force_o, dp_spike_i;
  logic [WW-1:0] dp_weight_o;
  logic [7:0]    dp_time_o;
  logic [SW-1:0] dp_state_o, dp_state_i;
  logic          spk_valid_o, spk_ready_i, busy_o;
  logic [IW-1:0] spk_id_o;

  evt_neuron_seq #(.N_NEURONS(N), .STATE_W(SW), .WEIGHT_W(WW), .IDX_W(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o),
    .evt_weight_i(evt_weight_i), .evt_time_i(evt_time_i), .evt_force_i(evt_force_i),
    .cfg_n_active_i(cfg_n_active_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .dp_enable_o(dp_enable_o), .dp_weight_o(dp_weight_o), .dp_time_o(dp_time_o),
    .dp_force_o(dp_force_o), .dp_state_o(dp_state_o), .dp_state_i(dp_state_i),
    .dp_spike_i(dp_spike_i),
    .spk_valid_o(spk_valid_o), .spk_ready_i(spk_ready_i), .spk_id_o(spk_id_o),
    .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {logic we; logic [IW-1:0] addr; logic [SW-1:0] data;} op_t;

  op_t           exp_ops[$];
  logic [IW-1:0] exp_spk[$];
  logic [SW-1:0] mem[N];
  logic [SW-1:0] ref_mem[N];
  logic [SW-1:0] snap[N];
  logic [IW-1:0] rd_addr;
  logic [63:0]   spike_mask;
  logic [WW-1:0] cur_w;
  logic [7:0]    cur_t;
  logic          cur_f;
  int            rdy_mode, stall_left, stall_cnt;
  int            tests, fails;
  logic          prev_read, prev_hold;
  logic [IW-1:0] prev_id, last_waddr;
  op_t           mon_op;
  logic [IW-1:0] mon_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Single-port SRAM with one-cycle read latency; read data is junk otherwise.
  always @(posedge clk_i) begin
    if (mem_req_o && mem_we_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
    end else if (mem_req_o) begin
      mem_rdata_i <= mem[mem_addr_o];
      rd_addr     <= mem_addr_o;
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  assign dp_state_i = dp_state_o + 32'(dp_time_o) + 32'(dp_weight_o) + 32'd1;
  assign dp_spike_i = dp_enable_o & (spike_mask[rd_addr] | dp_force_o);

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0: spk_ready_i = 1'b1;
      1: spk_ready_i = ($urandom_range(0, 2) != 0);
      default: begin
        if (spk_valid_o && stall_left > 0) begin
          spk_ready_i = 1'b0;
          stall_left--;
        end else begin
          spk_ready_i = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_read <= 1'b0;
      prev_hold <= 1'b0;
    end else begin
      check("busy_vs_ready", busy_o, !evt_ready_o);
      check("dp_enable_after_read", dp_enable_o, prev_read);
      if (busy_o) begin
        check("dp_weight", dp_weight_o, cur_w);
        check("dp_time", dp_time_o, cur_t);
        check("dp_force", dp_force_o, cur_f);
      end
      if (mem_req_o) begin
        check("mem_during_spike", spk_valid_o, 0);
        if (exp_ops.size() == 0) begin
          fail_now("unexpected_mem_op");
        end else begin
          mon_op = exp_ops.pop_front();
          check("mem_we", mem_we_o, mon_op.we);
          check("mem_addr", mem_addr_o, mon_op.addr);
          if (mon_op.we) begin
            check("mem_wdata", mem_wdata_o, mon_op.data);
            last_waddr <= mem_addr_o;
          end
        end
      end else begin
        check("mem_we_no_req", mem_we_o, 0);
      end
      if (prev_hold) begin
        check("spk_hold_valid", spk_valid_o, 1);
        check("spk_hold_id", spk_id_o, prev_id);
      end
      if (spk_valid_o) begin
        if (!spk_ready_i) begin
          stall_cnt++;
        end else if (exp_spk.size() == 0) begin
          fail_now("unexpected_spike");
        end else begin
          mon_id = exp_spk.pop_front();
          check("spk_id", spk_id_o, mon_id);
        end
      end
      prev_read <= mem_req_o & ~mem_we_o;
      prev_hold <= spk_valid_o & ~spk_ready_i;
      prev_id   <= spk_id_o;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (!evt_ready_o && g < 200) begin
      @(posedge clk_i); #1; g++;
    end
    if (!evt_ready_o) fail_now("idle_timeout");
  endtask

  // Present one event at an idle boundary and load the expected traffic for it.
  task automatic launch(input logic [WW-1:0] w, input logic [7:0] t, input logic f,
                        input int n_cfg, input logic [63:0] msk, input int mode,
                        output int ne, output int nspk);
    wait_idle();
    ne   = (n_cfg > N) ? N : n_cfg;
    nspk = 0;
    for (int i = 0; i < ne; i++) begin
      op_t o;
      o.we = 1'b0; o.addr = IW'(i); o.data = '0;
      exp_ops.push_back(o);
      ref_mem[i] = ref_mem[i] + 32'(t) + 32'(w) + 32'd1;
      o.we = 1'b1; o.data = ref_mem[i];
      exp_ops.push_back(o);
      if (msk[i] || f) begin
        exp_spk.push_back(IW'(i));
        nspk++;
      end
    end
    cur_w = w; cur_t = t; cur_f = f;
    spike_mask = msk; rdy_mode = mode; stall_left = 5; stall_cnt = 0;
    evt_weight_i = w; evt_time_i = t; evt_force_i = f;
    cfg_n_active_i = (IW+1)'(n_cfg);
    evt_valid_i = 1'b1;
    @(posedge clk_i); #1;
    evt_valid_i = 1'b0;
    evt_weight_i = WW'($urandom); evt_time_i = 8'($urandom); evt_force_i = 1'($urandom);
  endtask

  task automatic run_event(input logic [WW-1:0] w, input logic [7:0] t, input logic f,
                           input int n_cfg, input logic [63:0] msk, input int mode,
                           output int cycles);
    int ne, nspk;
    launch(w, t, f, n_cfg, msk, mode, ne, nspk);
    cycles = 0;
    while (!evt_ready_o && cycles < 5000) begin
      @(posedge clk_i); #1; cycles++;
    end
    check("sweep_cycles", cycles, 3 * ne + nspk + stall_cnt);
    check("ops_drained", exp_ops.size(), 0);
    check("spikes_drained", exp_spk.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, evt_ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_req"}, mem_req_o, 0);
    check({tag, "_we"}, mem_we_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_wdata"}, mem_wdata_o, 0);
    check({tag, "_spk_valid"}, spk_valid_o, 0);
    check({tag, "_spk_id"}, spk_id_o, 0);
    check({tag, "_dp_en"}, dp_enable_o, 0);
    check({tag, "_dp_w"}, dp_weight_o, 0);
    check({tag, "_dp_t"}, dp_time_o, 0);
    check({tag, "_dp_f"}, dp_force_o, 0);
  endtask

  initial begin
    int cyc, ne, nspk, g;
    tests = 0; fails = 0;
    rst_ni = 1'b0; evt_valid_i = 1'b0; evt_weight_i = '0; evt_time_i = '0;
    evt_force_i = 1'b0; cfg_n_active_i = '0; spk_ready_i = 1'b1;
    rdy_mode = 0; stall_left = 0; stall_cnt = 0; spike_mask = '0;
    cur_w = '0; cur_t = '0; cur_f = 1'b0; rd_addr = '0; last_waddr = '0;
    for (int i = 0; i < N; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[0] = 32'd100; ref_mem[0] = 32'd100;
    #23;
    check_reset_outputs("rst");
    @(posedge clk_i); #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("idle");

    // n=4, no spikes: 12 cycles, first write of neuron 0 is 100+5+3+1
    run_event(4'd3, 8'd5, 1'b0, 4, 64'h0, 0, cyc);
    check("n4_nospike_cycles", cyc, 12);
    check("n4_mem0_value", mem[0], 32'd109);

    run_event(4'd2, 8'd7, 1'b0, 4, 64'h0A, 0, cyc);
    check("n4_spike13_cycles", cyc, 14);

    run_event(4'd1, 8'd9, 1'b0, 4, 64'h0A, 2, cyc);
    check("n4_stall_cycles", cyc, 19);
    check("n4_stall_count", stall_cnt, 5);

    run_event(4'd4, 8'd1, 1'b1, 0, 64'hF, 0, cyc);
    check("n0_cycles", cyc, 0);
    check("n0_ready", evt_ready_o, 1);

    run_event(4'd5, 8'd2, 1'b0, N + 5, 64'h0, 0, cyc);
    check("sat_cycles", cyc, 3 * N);
    check("sat_last_addr", last_waddr, N - 1);

    for (int k = 0; k < 20; k++) begin
      int nc;
      nc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 6);
      run_event(WW'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), nc,
                {$urandom, $urandom}, $urandom_range(0, 1), cyc);
    end

    // Reset in EXEC of neuron 2: only neurons 0 and 1 were written back
    for (int i = 0; i < N; i++) snap[i] = ref_mem[i];
    launch(4'd6, 8'd11, 1'b0, 4, 64'h0, 0, ne, nspk);
    g = 0;
    while (!(dp_enable_o && rd_addr == 2) && g < 100) begin
      @(negedge clk_i); g++;
    end
    check("reach_exec2", dp_enable_o && rd_addr == 2, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_ops.delete();
    exp_spk.delete();
    for (int i = 0; i < N; i++) ref_mem[i] = snap[i];
    for (int i = 0; i < 2; i++) ref_mem[i] = ref_mem[i] + 32'd11 + 32'd6 + 32'd1;
    check("midrst_mem1", mem[1], ref_mem[1]);
    check("midrst_mem2_untouched", mem[2], snap[2]);
    @(posedge clk_i); #2 rst_ni = 1'b1;
    cur_w = '0; cur_t = '0; cur_f = 1'b0;
    run_event(4'd2, 8'd3, 1'b0, 3, 64'h1, 1, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
